// File: rtl/sfr_timer_pkg.sv
// Shared SFR address map and mode encoding for the 8051-style timer channels.
package sfr_timer_pkg;

  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_TL0  = 8'h8A;
  localparam logic [7:0] ADDR_TL1  = 8'h8B;
  localparam logic [7:0] ADDR_TH0  = 8'h8C;
  localparam logic [7:0] ADDR_TH1  = 8'h8D;

  // Bit addresses inside TCON (only meaningful with wr_bit_en=1).
  localparam logic [7:0] BIT_TR0 = 8'h8C;
  localparam logic [7:0] BIT_TF0 = 8'h8D;
  localparam logic [7:0] BIT_TR1 = 8'h8E;
  localparam logic [7:0] BIT_TF1 = 8'h8F;

  typedef enum logic [1:0] {
    MODE13       = 2'b00,
    MODE16       = 2'b01,
    MODE8_RELOAD = 2'b10,
    MODE_HALT    = 2'b11
  } tmr_mode_e;

  typedef struct packed {
    logic      gate;
    logic      ct;
    tmr_mode_e mode;
  } tmod_nib_t;

endpackage

// File: rtl/sfr_timer_pin_sync_edge.sv
// Multi-flop synchroniser for an idle-high async pin plus falling-edge detector.
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   vld_q;

  // vld_q marks when prev_q holds a genuine pin sample, so a pin held low
  // through reset does not look like a falling edge against the reset value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o = vld_q[SYNC_STAGES] & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sfr_timer.sv
// One 8051 timer/counter channel: SFR decode, gating, four counting modes, TFx flag.
module sfr_timer
  import sfr_timer_pkg::*;
#(
  parameter int TIMER_ID    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic       bit_in,
  input  logic       tick,
  input  logic       t_pin,
  input  logic       int_pin,
  input  logic       int_ack,
  output logic [7:0] tl_data,
  output logic [7:0] th_data,
  output logic [3:0] tmod_nib,
  output logic       tf,
  output logic       tr,
  output logic       ovf_pulse
);

  localparam logic [7:0] A_TL   = (TIMER_ID == 0) ? ADDR_TL0 : ADDR_TL1;
  localparam logic [7:0] A_TH   = (TIMER_ID == 0) ? ADDR_TH0 : ADDR_TH1;
  localparam logic [7:0] B_TR   = (TIMER_ID == 0) ? BIT_TR0  : BIT_TR1;
  localparam logic [7:0] B_TF   = (TIMER_ID == 0) ? BIT_TF0  : BIT_TF1;
  localparam int         TF_BIT = (TIMER_ID == 0) ? 5 : 7;
  localparam int         TR_BIT = TF_BIT - 1;

  logic [7:0] tl_q, tl_d, th_q, th_d;
  tmod_nib_t  tmod_q, tmod_d;
  logic       tf_q, tf_d, tr_q, tr_d, ovf_q, ovf_d;

  logic t_fall, int_sync, t_sync_unused, int_fall_unused;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_t_sync (
    .clock  (clock),
    .reset  (reset),
    .pin_i  (t_pin),
    .sync_o (t_sync_unused),
    .fall_o (t_fall)
  );

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
    .clock  (clock),
    .reset  (reset),
    .pin_i  (int_pin),
    .sync_o (int_sync),
    .fall_o (int_fall_unused)
  );

  logic        byte_wr, bit_wr, tl_wr, th_wr, tmod_wr, tcon_wr;
  logic        run, cnt_evt, ovf;
  logic [12:0] cnt13;
  logic [7:0]  tl_cnt, th_cnt;

  always_comb begin
    byte_wr = wr_en & ~wr_bit_en;
    bit_wr  = wr_en & wr_bit_en;
    tl_wr   = byte_wr && (addr == A_TL);
    th_wr   = byte_wr && (addr == A_TH);
    tmod_wr = byte_wr && (addr == ADDR_TMOD);
    tcon_wr = byte_wr && (addr == ADDR_TCON);

    run     = tr_q & (~tmod_q.gate | int_sync);
    cnt_evt = run & (tmod_q.ct ? t_fall : tick);

    tl_cnt = tl_q;
    th_cnt = th_q;
    cnt13  = '0;
    ovf    = 1'b0;
    if (cnt_evt) begin
      case (tmod_q.mode)
        MODE13: begin
          {ovf, cnt13} = {1'b0, th_q, tl_q[4:0]} + 14'd1;
          th_cnt = cnt13[12:5];
          tl_cnt = {tl_q[7:5], cnt13[4:0]};
        end
        MODE16:       {ovf, th_cnt, tl_cnt} = {1'b0, th_q, tl_q} + 17'd1;
        MODE8_RELOAD: begin
          if (tl_q == 8'hFF) begin
            tl_cnt = th_q;
            ovf    = 1'b1;
          end else begin
            tl_cnt = tl_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    // A CPU write to either counter byte takes the cycle: no carry-out is flagged.
    tl_d   = tl_wr ? data_in : tl_cnt;
    th_d   = th_wr ? data_in : th_cnt;
    ovf_d  = ovf & ~(tl_wr | th_wr);
    tmod_d = tmod_wr ? tmod_nib_t'(data_in[TIMER_ID*4 +: 4]) : tmod_q;

    tf_d = tf_q;
    if (int_ack)                   tf_d = 1'b0;
    if (tcon_wr)                   tf_d = data_in[TF_BIT];
    if (bit_wr && (addr == B_TF))  tf_d = bit_in;
    if (ovf_d)                     tf_d = 1'b1;

    tr_d = tr_q;
    if (tcon_wr)                   tr_d = data_in[TR_BIT];
    if (bit_wr && (addr == B_TR))  tr_d = bit_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tl_q   <= '0;
      th_q   <= '0;
      tmod_q <= '0;
      tf_q   <= 1'b0;
      tr_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tl_q   <= tl_d;
      th_q   <= th_d;
      tmod_q <= tmod_d;
      tf_q   <= tf_d;
      tr_q   <= tr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign tl_data   = tl_q;
  assign th_data   = th_q;
  assign tmod_nib  = tmod_q;
  assign tf        = tf_q;
  assign tr        = tr_q;
  assign ovf_pulse = ovf_q;

endmodule
